// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator key sequencer: keycode constants,
// the 2-bit operator type, the sequencer state type and a helper that
// tells apart keys the sequencer acts on from keys it ignores.
package calc_pkg;

    localparam logic [4:0] KEY_ADD      = 5'h00;
    localparam logic [4:0] KEY_SUB      = 5'h01;
    localparam logic [4:0] KEY_MUL      = 5'h02;
    localparam logic [4:0] KEY_DIV      = 5'h03;
    localparam logic [4:0] KEY_EQ       = 5'h04;
    localparam logic [4:0] KEY_CLR      = 5'h05;
    localparam logic [4:0] KEY_HEX_BASE = 5'h10;

    typedef logic [1:0] opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ALU = 2'd2
    } state_t;

    // Hex digits occupy 5'h10-5'h1F and commands occupy 5'h00-5'h05.
    // Any other code is dropped at the input and never reaches the FIFO.
    function automatic logic is_valid_key(input logic [4:0] code);
        return (code >= KEY_HEX_BASE) || (code <= KEY_CLR);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo
// Small synchronous FIFO that buffers keycodes between the keypad and the
// sequencer FSM. The head entry is visible combinationally on 'head'.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   push, push_data     write request and data
//   pop                 read request; head advances on the edge
//   head                oldest entry (undefined while empty)
//   full, empty         occupancy flags
//   drop                push refused this cycle because the FIFO is full
//   level               current occupancy, 0..DEPTH
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same
    // edge, because the freed slot is the one the write pointer targets.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
// Buffers keypad presses, decodes them one at a time and issues one-cycle
// strobes to the calculator register file. Operator and equals keys start
// the arithmetic unit and further keys are held until it reports done or
// the wait times out.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   newkey, keycode     one-cycle keypress and its 5-bit code
//   alu_done            arithmetic unit result-valid pulse
//   newhex, hexcode     digit strobe and value
//   newop, opcode       operator strobe; opcode also qualifies eq
//   eq, clr             equals and clear strobes
//   alu_start           start pulse for the arithmetic unit
//   busy                high while waiting for the arithmetic unit
//   fifo_level          keypress buffer occupancy
//   key_drop            pulse: a key was lost to a full buffer
//   timeout_err         sticky: the arithmetic unit never answered
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        newkey,
    input  logic [4:0]                  keycode,
    input  logic                        alu_done,
    output logic                        newhex,
    output logic [3:0]                  hexcode,
    output logic                        newop,
    output logic [1:0]                  opcode,
    output logic                        eq,
    output logic                        clr,
    output logic                        alu_start,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        key_drop,
    output logic                        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    opcode_t          last_op;
    opcode_t          last_op_next;

    logic             newhex_next;
    logic [3:0]       hexcode_next;
    logic             newop_next;
    logic [1:0]       opcode_next;
    logic             eq_next;
    logic             clr_next;
    logic             alu_start_next;
    logic             busy_next;
    logic             timeout_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic [4:0]       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;

    assign fifo_push = newkey && is_valid_key(keycode);
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (keycode),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop),
        .level     (fifo_level)
    );

    // State and all outputs are registered. The decode of the head key is
    // done on the pop edge so its strobe is high for exactly the ISSUE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            last_op     <= '0;
            newhex      <= 1'b0;
            hexcode     <= '0;
            newop       <= 1'b0;
            opcode      <= '0;
            eq          <= 1'b0;
            clr         <= 1'b0;
            alu_start   <= 1'b0;
            busy        <= 1'b0;
            key_drop    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            last_op     <= last_op_next;
            newhex      <= newhex_next;
            hexcode     <= hexcode_next;
            newop       <= newop_next;
            opcode      <= opcode_next;
            eq          <= eq_next;
            clr         <= clr_next;
            alu_start   <= alu_start_next;
            busy        <= busy_next;
            key_drop    <= fifo_drop;
            timeout_err <= timeout_next;
        end
    end

    // Next-state and next-output logic. Strobes default low so each one
    // lasts a single cycle; the ISSUE state uses the registered alu_start
    // to know whether the key it is presenting needs the arithmetic unit.
    always_comb begin
        state_next     = state;
        timer_next     = '0;
        last_op_next   = last_op;
        newhex_next    = 1'b0;
        hexcode_next   = '0;
        newop_next     = 1'b0;
        opcode_next    = '0;
        eq_next        = 1'b0;
        clr_next       = 1'b0;
        alu_start_next = 1'b0;
        busy_next      = 1'b0;
        timeout_next   = timeout_err;

        case (state)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_next = ST_ISSUE;
                    if (head >= KEY_HEX_BASE) begin
                        newhex_next  = 1'b1;
                        hexcode_next = head[3:0];
                    end else begin
                        case (head)
                            KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: begin
                                newop_next     = 1'b1;
                                opcode_next    = head[1:0];
                                last_op_next   = head[1:0];
                                alu_start_next = 1'b1;
                            end
                            KEY_EQ: begin
                                eq_next        = 1'b1;
                                opcode_next    = last_op;
                                alu_start_next = 1'b1;
                            end
                            KEY_CLR: begin
                                clr_next     = 1'b1;
                                last_op_next = '0;
                                timeout_next = 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            ST_ISSUE: begin
                if (alu_start) begin
                    state_next = ST_WAIT_ALU;
                    busy_next  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_WAIT_ALU: begin
                // A done pulse on the expiry cycle wins over the timeout.
                if (alu_done) begin
                    state_next = ST_IDLE;
                end else if (timer == CNT_W'(TIMEOUT - 1)) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    timer_next = timer + CNT_W'(1);
                    busy_next  = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer
// Scoreboard bench for calc_key_sequencer. Every accepted key pushes the
// strobe it should eventually produce into a queue; a monitor pops that
// queue whenever a strobe appears and compares kind, value and alu_start.
// A responder answers alu_start with alu_done after a chosen delay.
module tb_calc_key_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 64;

    localparam int K_HEX = 0;
    localparam int K_OP  = 1;
    localparam int K_EQ  = 2;
    localparam int K_CLR = 3;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       newkey;
    logic [4:0] keycode;
    logic       alu_done;
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic [1:0] opcode;
    logic       eq;
    logic       clr;
    logic       alu_start;
    logic       busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic       key_drop;
    logic       timeout_err;

    exp_t exp_q[$];
    int   model_last_op;
    int   drops_expected;
    int   alu_delay;
    int   checks;
    int   errors;

    calc_key_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .newkey      (newkey),
        .keycode     (keycode),
        .alu_done    (alu_done),
        .newhex      (newhex),
        .hexcode     (hexcode),
        .newop       (newop),
        .opcode      (opcode),
        .eq          (eq),
        .clr         (clr),
        .alu_start   (alu_start),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .key_drop    (key_drop),
        .timeout_err (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Presents one key for one cycle and records what the sequencer should
    // do with it in terms of the keypad rules only.
    task automatic applyStimulus(input logic [4:0] code, input bit expect_drop);
        exp_t e;
        @(negedge clock);
        newkey  = 1'b1;
        keycode = code;
        if (expect_drop) begin
            drops_expected++;
        end else if (code >= 5'h10) begin
            e.kind = K_HEX; e.val = int'(code[3:0]); exp_q.push_back(e);
        end else if (code <= 5'h03) begin
            e.kind = K_OP; e.val = int'(code); exp_q.push_back(e);
            model_last_op = int'(code);
        end else if (code == 5'h04) begin
            e.kind = K_EQ; e.val = model_last_op; exp_q.push_back(e);
        end else if (code == 5'h05) begin
            e.kind = K_CLR; e.val = 0; exp_q.push_back(e);
            model_last_op = 0;
        end
        @(negedge clock);
        newkey  = 1'b0;
        keycode = '0;
    endtask

    task automatic waitBusy(input logic val, input string name);
        int n;
        n = 0;
        while (busy !== val && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, int'(busy), int'(val));
    endtask

    task automatic measureBusy(output int cnt);
        cnt = 0;
        while (busy && cnt < 300) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Arithmetic unit stand-in: -1 never answers, -2 answers after a random
    // delay, otherwise answers after exactly alu_delay cycles.
    initial begin
        int d;
        alu_done = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && alu_start && alu_delay != -1) begin
                d = (alu_delay == -2) ? int'($urandom_range(1, 20)) : alu_delay;
                repeat (d) @(negedge clock);
                alu_done = 1'b1;
                @(negedge clock);
                alu_done = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        logic [3:0] strobes;
        logic [3:0] want;
        exp_t       e;
        if (reset) begin
            strobes = {newhex, newop, eq, clr};
            if (strobes != 4'b0000) begin
                if ($countones(strobes) != 1) begin
                    checkOutput("one_strobe_only", $countones(strobes), 1);
                end
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe", int'(strobes), 0);
                end else begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        K_HEX:   want = 4'b1000;
                        K_OP:    want = 4'b0100;
                        K_EQ:    want = 4'b0010;
                        default: want = 4'b0001;
                    endcase
                    checkOutput("strobe_kind", int'(strobes), int'(want));
                    if (e.kind == K_HEX) begin
                        checkOutput("hexcode", int'(hexcode), e.val);
                    end
                    if (e.kind == K_OP || e.kind == K_EQ) begin
                        checkOutput("opcode", int'(opcode), e.val);
                    end
                    if (e.kind == K_CLR) begin
                        checkOutput("clr_clears_timeout", int'(timeout_err), 0);
                    end
                    checkOutput("alu_start_with_strobe", int'(alu_start),
                                (e.kind == K_OP || e.kind == K_EQ) ? 1 : 0);
                end
            end else if (alu_start) begin
                checkOutput("stray_alu_start", int'(alu_start), 0);
            end
            if (key_drop) begin
                checkOutput("key_drop_expected", (drops_expected > 0) ? 1 : 0, 1);
                if (drops_expected > 0) begin
                    drops_expected--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         cnt;
        int         r;
        int         n;
        bit         saw_activity;
        logic [4:0] code;

        checks         = 0;
        errors         = 0;
        drops_expected = 0;
        model_last_op  = 0;
        alu_delay      = -2;
        newkey         = 1'b0;
        keycode        = '0;
        reset          = 1'b1;
        #3 reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_strobes", int'({newhex, newop, eq, clr, alu_start}), 0);
        checkOutput("reset_status", int'({busy, key_drop, timeout_err}), 0);
        checkOutput("reset_values", int'({hexcode, opcode}), 0);
        checkOutput("reset_level", int'(fifo_level), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] test 1: digit keys and latency");
        applyStimulus(5'h13, 1'b0);
        checkOutput("hex_not_early", int'(newhex), 0);
        @(negedge clock);
        checkOutput("hex_latency_1", int'(newhex), 1);
        checkOutput("digit_not_busy_1", int'(busy), 0);
        repeat (2) @(negedge clock);
        applyStimulus(5'h1A, 1'b0);
        @(negedge clock);
        checkOutput("hex_latency_2", int'(newhex), 1);
        @(negedge clock);
        checkOutput("digit_not_busy_2", int'(busy), 0);

        $display("[TB] test 2: operator with ALU handshake");
        alu_delay = 10;
        applyStimulus(5'h00, 1'b0);
        waitBusy(1'b1, "op_busy_rise");
        measureBusy(cnt);
        checkOutput("op_busy_len", cnt, 10);
        checkOutput("op_no_timeout", int'(timeout_err), 0);

        $display("[TB] test 3: FIFO fill and overflow during WAIT_ALU");
        alu_delay = 40;
        applyStimulus(5'h00, 1'b0);
        waitBusy(1'b1, "fill_busy_rise");
        applyStimulus(5'h11, 1'b0);
        applyStimulus(5'h12, 1'b0);
        applyStimulus(5'h1E, 1'b0);
        applyStimulus(5'h17, 1'b0);
        checkOutput("fifo_level_full", int'(fifo_level), 4);
        applyStimulus(5'h19, 1'b1);
        checkOutput("key_drop_pulse", int'(key_drop), 1);
        checkOutput("fifo_level_after_drop", int'(fifo_level), 4);
        waitDrain("fill_drained");
        checkOutput("fill_level_empty", int'(fifo_level), 0);

        $display("[TB] test 4: ALU timeout then clear");
        alu_delay = -1;
        applyStimulus(5'h02, 1'b0);
        waitBusy(1'b1, "to_busy_rise");
        measureBusy(cnt);
        checkOutput("timeout_busy_len", cnt, TIMEOUT);
        checkOutput("timeout_err_set", int'(timeout_err), 1);
        applyStimulus(5'h05, 1'b0);
        @(negedge clock);
        checkOutput("clr_strobe", int'(clr), 1);
        @(negedge clock);
        checkOutput("timeout_err_cleared", int'(timeout_err), 0);

        $display("[TB] test 5: equals carries last operator, invalid key ignored");
        alu_delay = 5;
        applyStimulus(5'h01, 1'b0);
        applyStimulus(5'h04, 1'b0);
        waitDrain("eq_drained");
        applyStimulus(5'h08, 1'b0);
        checkOutput("invalid_no_push", int'(fifo_level), 0);
        repeat (4) @(negedge clock);
        checkOutput("invalid_no_drop", drops_expected, 0);

        $display("[TB] test 6: reset during WAIT_ALU");
        alu_delay = 30;
        applyStimulus(5'h03, 1'b0);
        waitBusy(1'b1, "rst_busy_rise");
        applyStimulus(5'h14, 1'b0);
        applyStimulus(5'h15, 1'b0);
        applyStimulus(5'h16, 1'b0);
        checkOutput("rst_level_before", int'(fifo_level), 3);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_async_outputs",
                    int'({newhex, newop, eq, clr, alu_start, busy, key_drop, timeout_err}), 0);
        checkOutput("rst_async_level", int'(fifo_level), 0);
        exp_q.delete();
        model_last_op = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        saw_activity = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (busy || newhex || newop || eq || clr || alu_start || fifo_level != 0) begin
                saw_activity = 1'b1;
            end
        end
        checkOutput("rst_ignores_alu_done", int'(saw_activity), 0);

        $display("[TB] random phase");
        alu_delay = -2;
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                code = 5'h10 + 5'($urandom_range(0, 15));
            end else if (r < 75) begin
                code = 5'($urandom_range(0, 3));
            end else if (r < 85) begin
                code = 5'h04;
            end else if (r < 90) begin
                code = 5'h05;
            end else begin
                code = 5'($urandom_range(6, 15));
            end
            n = 0;
            while (exp_q.size() >= FIFO_DEPTH && n < 500) begin
                @(negedge clock);
                n++;
            end
            if (n >= 500) begin
                checkOutput("space_wait", n, 0);
            end
            applyStimulus(code, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        waitDrain("random_drained");
        checkOutput("random_level_empty", int'(fifo_level), 0);
        checkOutput("random_no_timeout", int'(timeout_err), 0);
        checkOutput("all_drops_seen", drops_expected, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Sits between the raw keypad inputs and the calculator datapath: keypad decode, operand registers and arithmetic unit.
- Buffers keypresses in a small FIFO and decodes each one.
- Issues one-cycle strobes (newhex/newop/eq/clr) to the register file.
- Holds further keys while a multi-cycle arithmetic operation is running, using an alu_start/alu_done handshake with a timeout.

Parameters:
- FIFO_DEPTH, 4, keypress buffer entries (power of 2, 2..16).
- TIMEOUT, 64, max cycles waiting for alu_done before flagging an error.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- newkey  input  1  high for one cycle per keypress.
- keycode  input  5  key pressed, valid with newkey.
- alu_done  input  1  one-cycle pulse from the arithmetic unit when its result is valid.
- newhex  output  1  one-cycle strobe: shift hexcode into the entry register.
- hexcode  output  4  digit value, valid with newhex.
- newop  output  1  one-cycle strobe: operator key.
- opcode  output  2  operator, valid with newop/eq.
- eq  output  1  one-cycle strobe: equals key.
- clr  output  1  one-cycle strobe: clear registers.
- alu_start  output  1  one-cycle strobe: start an arithmetic operation.
- busy  output  1  high while in WAIT_ALU.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- key_drop  output  1  one-cycle pulse: a key was lost because the FIFO was full.
- timeout_err  output  1  sticky; set on ALU timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, FIFO empty, state IDLE, timeout counter 0.
  - Reset mid-operation abandons any WAIT_ALU and discards queued keys.
- Keycode map (decided):
  - 5'h10-5'h1F: hex digit keycode[3:0].
  - 5'h00 add (op 0), 5'h01 subtract (op 1), 5'h02 multiply (op 2), 5'h03 divide (op 3).
  - 5'h04 equals, 5'h05 clear.
  - All other codes are ignored: never enqueued, no strobe, no key_drop.
- FIFO push and pop:
  - A valid newkey pushes on the same edge.
  - Full with no simultaneous pop: key discarded, key_drop=1 for the next cycle.
  - Full with a simultaneous pop: push accepted, level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM, states IDLE, ISSUE, WAIT_ALU:
  - IDLE: if the FIFO is non-empty, pop the head into the decode register and go to ISSUE. Otherwise stay.
  - ISSUE, one cycle, registered outputs asserted this cycle:
    - digit: newhex=1, hexcode=digit → IDLE.
    - clear: clr=1, timeout_err cleared → IDLE.
    - operator: newop=1, opcode, alu_start=1 → WAIT_ALU.
    - equals: eq=1, opcode=last latched operator (0 after reset/clear), alu_start=1 → WAIT_ALU.
  - WAIT_ALU:
    - busy=1; keys continue to enqueue, none are popped.
    - alu_done=1 → IDLE.
    - TIMEOUT cycles without done: timeout_err=1 → IDLE.
    - alu_done arriving in the same cycle as expiry counts as done: no error.
    - alu_done outside WAIT_ALU is ignored.
- Latency:
  - Key sampled at edge N, FIFO was empty, state IDLE: popped at edge N+1, strobe high during cycle N+1..N+2.
  - Throughput is one digit key per 2 cycles.
- Only one of newhex/newop/eq/clr is high in any cycle.
- fifo_level updates on the push/pop edge.

Decomposition:
- Shared package calc_pkg:
  - keycode constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_EQ, KEY_CLR, KEY_HEX_BASE).
  - opcode typedef (2-bit).
  - FSM state typedef.
- One natural sub-module: key_fifo (parameterised synchronous FIFO with push, pop, full, empty, level).

Test Plan:
1. Reset then keys 5'h13, 5'h1A 3 cycles apart → newhex pulses with hexcode 3 then A; each strobe 2 cycles after its key; busy stays 0.
2. Key 5'h00 with alu_done returned 10 cycles after alu_start → newop=1 with opcode=0 and alu_start=1 in the same cycle; busy=1 for 10 cycles; back to IDLE.
3. During WAIT_ALU, send 5 digit keys with FIFO_DEPTH=4 → fifo_level reaches 4, 5th key gives key_drop pulse; after alu_done the 4 digits issue in order.
4. Key 5'h02 with alu_done never returned, TIMEOUT=64 → timeout_err=1 after 64 cycles; then key 5'h05 → clr pulse and timeout_err=0.
5. Keys 5'h01 then 5'h04 → eq strobe carries opcode=1; keycode 5'h08 → no strobe, no push.
6. Assert reset low mid-WAIT_ALU with 3 keys queued → all outputs 0 immediately and fifo_level=0; subsequent alu_done is ignored.
